// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with byte-enable
// writes, optional hardwired-zero r0, optional write-to-read bypass and a
// per-register pending scoreboard for issue-stage stall decisions.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS),
    localparam int CW      = $clog2(NUM_REGS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    output logic [CW-1:0]            pending_cnt
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0]        mem_q [NUM_REGS];
    logic [DATA_W-1:0]        mem_d [NUM_REGS];
    logic [NUM_REGS-1:0]      pend_q, pend_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
    logic                     wr_ok, rsv_ok;
    logic [DATA_W-1:0]        wr_merged;

    // An address names a real, writable register: in range and not a hardwired r0.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Write merge, register-file next state and pending scoreboard next state.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave it unassigned and infer a latch.
        wr_ok     = wr_en && addr_ok(wr_addr);
        rsv_ok    = rsv_en && addr_ok(rsv_addr);
        wr_merged = '0;
        mem_d     = mem_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        if (wr_ok) begin
            wr_merged = mem_q[wr_addr];
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) wr_merged[8*k +: 8] = wr_data[8*k +: 8];
            end
            mem_d[wr_addr]  = wr_merged;
            pend_d[wr_addr] = 1'b0;
            // A reserve to the same register re-arms it, so nothing is retired.
            if (pend_q[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr))) cnt_d = cnt_d - CW'(1);
        end
        // Reserve is applied last so a new producer wins over a retiring write.
        if (rsv_ok) begin
            pend_d[rsv_addr] = 1'b1;
            if (!pend_q[rsv_addr]) cnt_d = cnt_d + CW'(1);
        end
    end

    // Read ports: registered data/busy, bypassing a same-cycle write when enabled.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_en[i]) begin
                rd_data_d[i*DATA_W +: DATA_W] = '0;
                rd_busy_d[i]                  = 1'b0;
                if (addr_ok(rd_addr[i*AW +: AW])) begin
                    if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr[i*AW +: AW]))
                        rd_data_d[i*DATA_W +: DATA_W] = wr_merged;
                    else
                        rd_data_d[i*DATA_W +: DATA_W] = mem_q[rd_addr[i*AW +: AW]];
                    // Busy reflects the pending state as it will be after this edge.
                    rd_busy_d[i] = pend_d[rd_addr[i*AW +: AW]];
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage array is reset too, because a cleared file must read back as all zeros.
            for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
            pend_q    <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the pre-edge values of the others.
            mem_q     <= mem_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_busy     = rd_busy_q;
    assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives two regfile_mp instances (32 regs with bypass, and
// 20 regs without bypass) from shared stimulus and compares both against an
// array-based reference model, with directed scenarios then random traffic.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int AW = 5;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data_a, rd_data_b;
    logic [NR-1:0]    busy_a, busy_b;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [3:0]       wr_be;
    logic [DW-1:0]    wr_data;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic [5:0]       cnt_a;
    logic [4:0]       cnt_b;

    int total;
    int bad;

    // Reference state: index 0 models the 32-register bypassing DUT, index 1 the 20-register non-bypassing one.
    logic [31:0] m_mem  [2][32];
    bit          m_pend [2][32];
    int          m_cnt  [2];
    logic [31:0] m_rd   [2][NR];
    bit          m_busy [2][NR];

    regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_busy(busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending_cnt(cnt_a)
    );

    regfile_mp #(.DATA_W(32), .NUM_REGS(20), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[k][r]  = '0;
                m_pend[k][r] = 1'b0;
            end
            for (int p = 0; p < NR; p++) begin
                m_rd[k][p]   = '0;
                m_busy[k][p] = 1'b0;
            end
            m_cnt[k] = 0;
        end
    endtask

    // One clock edge of the architectural rules, applied to both models.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int          nregs;
            bit          byp;
            bit          wv, rv;
            int          a;
            logic [31:0] old_mem [32];
            nregs = (k == 0) ? 32 : 20;
            byp   = (k == 0);
            for (int r = 0; r < 32; r++) old_mem[r] = m_mem[k][r];
            wv = wr_en  && (int'(wr_addr)  < nregs) && (wr_addr  != 0);
            rv = rsv_en && (int'(rsv_addr) < nregs) && (rsv_addr != 0);
            if (wv) begin
                for (int b = 0; b < 4; b++)
                    if (wr_be[b]) m_mem[k][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                m_pend[k][wr_addr] = 1'b0;
            end
            if (rv) m_pend[k][rsv_addr] = 1'b1;
            m_cnt[k] = 0;
            for (int r = 0; r < 32; r++) if (m_pend[k][r]) m_cnt[k]++;
            for (int p = 0; p < NR; p++) begin
                if (rd_en[p]) begin
                    a = int'(rd_addr[p*AW +: AW]);
                    if (a != 0 && a < nregs) begin
                        m_rd[k][p]   = byp ? m_mem[k][a] : old_mem[a];
                        m_busy[k][p] = m_pend[k][a];
                    end else begin
                        m_rd[k][p]   = '0;
                        m_busy[k][p] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int p = 0; p < NR; p++) begin
            check($sformatf("a_rd_data%0d", p), rd_data_a[p*DW +: DW], m_rd[0][p]);
            check($sformatf("a_rd_busy%0d", p), 32'(busy_a[p]), 32'(m_busy[0][p]));
            check($sformatf("b_rd_data%0d", p), rd_data_b[p*DW +: DW], m_rd[1][p]);
            check($sformatf("b_rd_busy%0d", p), 32'(busy_b[p]), 32'(m_busy[1][p]));
        end
        check("a_pending_cnt", 32'(cnt_a), 32'(m_cnt[0]));
        check("b_pending_cnt", 32'(cnt_b), 32'(m_cnt[1]));
    endtask

    task automatic idle();
        rd_en    = '0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_be    = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic set_wr(input int a, input logic [3:0] be, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_be   = be;
        wr_data = d;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_en[p]            = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_rsv(input int a);
        rsv_en   = 1'b1;
        rsv_addr = AW'(a);
    endtask

    // Inputs are set at the negedge; the edge is modelled, then outputs are compared at the next negedge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Asynchronous reset mid-cycle wipes contents and outputs.
        set_wr(5, 4'hF, 32'hDEADBEEF); cycle();
        set_rd(0, 5); set_rd(1, 5); cycle();
        check("r5_before_rst", rd_data_a[31:0], 32'hDEADBEEF);
        cycle();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        check("rst_data_now", rd_data_a[31:0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_rd(0, 5); set_rd(1, 5); cycle();
        check("r5_after_rst", rd_data_a[31:0], 32'h0);

        // Byte-enable merge.
        set_wr(3, 4'hF, 32'h11223344); cycle();
        set_wr(3, 4'b0101, 32'hAABBCCDD); cycle();
        set_rd(0, 3); cycle();
        check("byte_merge", rd_data_a[31:0], 32'h11BB33DD);

        // Same-cycle write and read of r7 on both ports.
        set_wr(7, 4'hF, 32'h0); cycle();
        set_wr(7, 4'hF, 32'h12345678); set_rd(0, 7); set_rd(1, 7); cycle();
        check("bypass_a_p0", rd_data_a[31:0], 32'h12345678);
        check("bypass_a_p1", rd_data_a[63:32], 32'h12345678);
        check("nobypass_b_p0", rd_data_b[31:0], 32'h0);
        check("nobypass_b_p1", rd_data_b[63:32], 32'h0);
        set_rd(0, 7); set_rd(1, 7); cycle();
        check("nobypass_b_next", rd_data_b[31:0], 32'h12345678);

        // Hardwired zero register ignores writes and reservations.
        set_wr(0, 4'hF, 32'hFFFFFFFF); set_rsv(0); cycle();
        set_rd(0, 0); set_rd(1, 0); cycle();
        check("zero_data", rd_data_a[31:0], 32'h0);
        check("zero_busy", 32'(busy_a[0]), 32'h0);
        check("zero_cnt", 32'(cnt_a), 32'h0);

        // Scoreboard reserve / clear / reserve-wins.
        set_rsv(4); cycle();
        check("sb_cnt1", 32'(cnt_a), 32'd1);
        set_rsv(9); cycle();
        check("sb_cnt2", 32'(cnt_a), 32'd2);
        set_rd(0, 4); cycle();
        check("sb_busy_r4", 32'(busy_a[0]), 32'd1);
        set_wr(4, 4'hF, 32'hCAFE0004); cycle();
        check("sb_cnt_after_wr", 32'(cnt_a), 32'd1);
        set_rd(0, 4); cycle();
        check("sb_r4_free", 32'(busy_a[0]), 32'd0);
        set_rsv(9); set_wr(9, 4'hF, 32'h99); set_rd(1, 9); cycle();
        check("sb_rsv_wins_cnt", 32'(cnt_a), 32'd1);
        check("sb_rsv_wins_busy", 32'(busy_a[1]), 32'd1);

        // Fill every valid register of the 20-entry file, then poke out of range.
        for (int r = 1; r < 20; r++) begin
            set_rsv(r); cycle();
        end
        check("sat_cnt_b", 32'(cnt_b), 32'd19);
        set_wr(25, 4'hF, 32'h25252525); set_rd(0, 25); cycle();
        check("oor_data_b", rd_data_b[31:0], 32'h0);
        check("oor_busy_b", 32'(busy_b[0]), 32'h0);
        check("oor_cnt_b", 32'(cnt_b), 32'd19);
        set_rsv(25); cycle();
        check("oor_rsv_cnt_b", 32'(cnt_b), 32'd19);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rd_en    = NR'($urandom);
            for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 31));
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom_range(0, 31));
            wr_be    = 4'($urandom);
            wr_data  = $urandom;
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = AW'($urandom_range(0, 31));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the datapath's fixed 32x32 register file.
- Configurable width, depth and number of read ports; byte-enable writes; optional hardwired-zero register 0; optional same-cycle write-to-read bypass.
- Adds a per-register pending scoreboard so issue logic can stall on registers that are still awaiting a write.
- Sits between the decode/issue stage (reads, reservations) and writeback (writes).
- Single clock edge (posedge) for all state; asynchronous clear.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- NUM_REGS, 32, number of registers; AW = $clog2(NUM_REGS), derived localparam.
- NUM_RD, 2, number of read ports.
- ZERO_REG, 1, 1 = register 0 reads 0; writes and reservations to it are ignored.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read; 0 = the read returns the pre-write value.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*AW  read addresses; port i is at [i*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  registered read data; port i is at [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  registered pending flag of the addressed register.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_be  in  DATA_W/8  byte enables; bit k covers [8k+7:8k].
- wr_data  in  DATA_W  write data.
- rsv_en  in  1  reserve (mark pending) enable.
- rsv_addr  in  AW  register to reserve.
- pending_cnt  out  $clog2(NUM_REGS+1)  number of registers currently pending.

Behaviour:
- Reset (rst_n=0, asynchronous): all registers, rd_data, rd_busy, pending bits and pending_cnt clear to 0 immediately. All ports are ignored while reset is low. First update occurs on the first posedge with rst_n=1.
- Write:
  - On posedge with wr_en=1 and a valid address, each byte with wr_be[k]=1 takes wr_data; other bytes hold.
  - wr_be=0 writes nothing, but still clears pending.
  - Valid address means wr_addr < NUM_REGS, and not 0 when ZERO_REG=1. Invalid writes are a no-op, including on pending state.
- Read:
  - Latency is 1 cycle. rd_en[i]=1 at edge N loads rd_data[i] at edge N.
  - rd_en[i]=0 holds the previous rd_data[i] and rd_busy[i].
  - Out-of-range address, or address 0 with ZERO_REG=1, returns 0 with busy=0.
- Bypass:
  - BYPASS=1 and a valid write to the same address in the same cycle: rd_data = byte-merge of the old value (bytes with be=0) and wr_data (bytes with be=1).
  - BYPASS=0: the old value is returned.
- Ports are independent: all NUM_RD ports may hit the same or different addresses in the same cycle.
- Scoreboard, per register, next pending state:
  - rsv valid: 1.
  - Else, write valid: 0.
  - Else: hold.
  - Reserve wins over a simultaneous write to the same register; it represents a new producer.
  - Reserving an already-pending register leaves it pending.
- rd_busy[i] loads the next (post-edge) pending state of rd_addr[i]:
  - A same-cycle write without a reserve gives busy=0.
  - A same-cycle reserve gives busy=1.
- pending_cnt: registered, always equals the popcount of the pending bits after the edge.
  - Delta per edge: +1 for a reserve of a non-pending register.
  - Delta per edge: -1 for a clearing write of a pending register.
  - Both apply when reserve and write target different registers.
  - Net 0 for reserve and write to the same already-pending register.
  - Never exceeds NUM_REGS; never underflows.
- Register contents do not otherwise change; there is no read-modify on read.

Test Plan:
- Reset: write 0xDEADBEEF to r5, pulse rst_n low mid-cycle -> rd_data, rd_busy, pending_cnt are 0 at once; a subsequent read of r5 returns 0x00000000.
- Byte enables: r3=0x11223344, then write 0xAABBCCDD with be=4'b0101 -> next read returns 0x11BB33DD.
- Bypass: r7=0x0, same cycle write r7=0x12345678 (be=1111) and read r7 on both ports -> BYPASS=1 both ports 0x12345678; BYPASS=0 both 0x00000000, next-cycle read 0x12345678.
- Zero register: ZERO_REG=1, write r0=0xFFFFFFFF and reserve r0 -> read r0 returns 0, busy=0, pending_cnt unchanged.
- Scoreboard:
  - Reserve r4, then r9 -> pending_cnt 1, then 2.
  - Read r4 -> busy=1.
  - Write r4 -> pending_cnt 1, read r4 busy=0.
  - Reserve and write r9 same cycle -> r9 stays pending, pending_cnt 1.
- Saturation and out-of-range: NUM_REGS=20, reserve all 19 valid registers -> pending_cnt=19. Write and read addr 25 -> no change, read returns 0.
